// File: rtl/mips_pkg.sv
// Shared types for the memory-stage store path.
// Store-buffer entry layout, FSM states and lane constants.
package mips_pkg;

  localparam int LANE_MSB  = 3;
  localparam logic [3:0] WORD_MASK = 4'b1111;
  localparam int WA_W = 30;

  typedef logic [0:LANE_MSB][7:0] lanes_t;

  typedef struct packed {
    logic [WA_W-1:0] word_addr;
    lanes_t          lanes;
    logic [3:0]      mask;
  } sb_entry_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } sb_state_t;

endpackage

// File: rtl/store_lane_pack.sv
// Big-endian store lane packer, inverse of load extraction.
// Ports: data/is_word/offset in; lanes[0:3] and mask out.
module store_lane_pack
  import mips_pkg::*;
(
  input  logic [31:0] data,
  input  logic        is_word,
  input  logic [1:0]  offset,
  output lanes_t      lanes,
  output logic [3:0]  mask
);

  logic [1:0] lane;

  // Byte offset 0 is the most significant lane.
  assign lane = 2'(LANE_MSB) - offset;

  always_comb begin
    lanes = '0;
    mask  = '0;
    if (is_word) begin
      lanes[3] = data[31:24];
      lanes[2] = data[23:16];
      lanes[1] = data[15:8];
      lanes[0] = data[7:0];
      mask     = WORD_MASK;
    end else begin
      lanes[lane] = data[7:0];
      mask[lane]  = 1'b1;
    end
  end

endmodule

// File: rtl/store_unit.sv
// Store buffer: packs stores, queues them, drains to dcache.
// Ports: st_* request, cache_* drain, ld_* hazard, halt/drained.
module store_unit
  import mips_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic              is_word,
  output logic              cache_we,
  input  logic              cache_ready,
  output logic [ADDR_W-1:0] cache_addr,
  output logic [7:0]        cache_data_in [0:3],
  output logic [3:0]        cache_byte_mask,
  input  logic [ADDR_W-1:0] ld_check_addr,
  output logic              ld_hit,
  input  logic              halted_controller,
  output logic              drained
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    count;
  logic [DEPTH-1:0] vld;
  sb_state_t        state;
  sb_entry_t        mem [DEPTH];
  sb_entry_t        head;

  logic   full;
  logic   empty;
  logic   enq;
  logic   deq;
  lanes_t pk_lanes;
  logic [3:0] pk_mask;
  logic   unused_ld_lsb;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

  // Ready looks only at registered state; a same-cycle
  // dequeue does not open a slot.
  assign st_ready = !full && (state == RUN);
  assign enq      = st_valid && st_ready;
  assign cache_we = !empty;
  assign deq      = cache_we && cache_ready;

  store_lane_pack u_pack (
    .data    (st_data),
    .is_word (is_word),
    .offset  (st_addr[1:0]),
    .lanes   (pk_lanes),
    .mask    (pk_mask)
  );

  always_ff @(posedge clk) begin
    if (enq) begin
      mem[wr_ptr].word_addr <= WA_W'(st_addr[ADDR_W-1:2]);
      mem[wr_ptr].lanes     <= pk_lanes;
      mem[wr_ptr].mask      <= pk_mask;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      vld    <= '0;
      state  <= RUN;
    end else begin
      if (deq) begin
        rd_ptr      <= rd_ptr + 1'b1;
        vld[rd_ptr] <= 1'b0;
      end
      if (enq) begin
        wr_ptr      <= wr_ptr + 1'b1;
        vld[wr_ptr] <= 1'b1;
      end
      if (enq && !deq)
        count <= count + 1'b1;
      else if (deq && !enq)
        count <= count - 1'b1;
      unique case (state)
        RUN:     if (halted_controller) state <= DRAIN;
        DRAIN:   if (empty) state <= DONE;
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  assign drained = (state == DONE);

  assign head            = mem[rd_ptr];
  assign cache_addr      = {head.word_addr[ADDR_W-3:0], 2'b00};
  assign cache_byte_mask = head.mask;

  always_comb begin
    for (int i = 0; i < 4; i++)
      cache_data_in[i] = head.lanes[i];
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld[i] && mem[i].word_addr ==
          WA_W'(ld_check_addr[ADDR_W-1:2]))
        ld_hit = 1'b1;
  end

  assign unused_ld_lsb = ^ld_check_addr[1:0];

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit against a queue model.
// Directed test-plan steps followed by a randomized phase.
module tb_store_unit;

  localparam int DEPTH = 4;

  logic        clk = 0;
  logic        reset;
  logic        st_valid;
  logic        st_ready;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic        is_word;
  logic        cache_we;
  logic        cache_ready;
  logic [31:0] cache_addr;
  logic [7:0]  cache_data_in [0:3];
  logic [3:0]  cache_byte_mask;
  logic [31:0] ld_check_addr;
  logic        ld_hit;
  logic        halted_controller;
  logic        drained;

  store_unit #(.DEPTH(DEPTH), .ADDR_W(32)) dut (
    .clk               (clk),
    .reset             (reset),
    .st_valid          (st_valid),
    .st_ready          (st_ready),
    .st_addr           (st_addr),
    .st_data           (st_data),
    .is_word           (is_word),
    .cache_we          (cache_we),
    .cache_ready       (cache_ready),
    .cache_addr        (cache_addr),
    .cache_data_in     (cache_data_in),
    .cache_byte_mask   (cache_byte_mask),
    .ld_check_addr     (ld_check_addr),
    .ld_hit            (ld_hit),
    .halted_controller (halted_controller),
    .drained           (drained)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] lanes;
    logic [3:0]  mask;
  } ent_t;

  ent_t q[$];
  bit   m_halt;
  bit   m_done;
  int   total;
  int   passed;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  function automatic ent_t pack(logic [31:0] a,
                                logic [31:0] d, logic w);
    ent_t e;
    int   b;
    e.addr = {a[31:2], 2'b00};
    if (w) begin
      e.lanes = d;
      e.mask  = 4'hF;
    end else begin
      b = 3 - int'(a % 4);
      e.lanes = {24'h0, d[7:0]} << (8 * b);
      e.mask  = 4'(1 << b);
    end
    return e;
  endfunction

  function automatic bit m_ready();
    return q.size() < DEPTH && !m_halt;
  endfunction

  function automatic bit m_hit(logic [31:0] a);
    foreach (q[i])
      if ((q[i].addr >> 2) == (a >> 2)) return 1;
    return 0;
  endfunction

  task automatic check_outs();
    chk("st_ready", st_ready, m_ready());
    chk("cache_we", cache_we, q.size() != 0);
    chk("ld_hit", ld_hit, m_hit(ld_check_addr));
    chk("drained", drained, m_done);
    if (q.size() != 0) begin
      chk("cache_addr", cache_addr, q[0].addr);
      chk("mask", cache_byte_mask, q[0].mask);
      for (int i = 0; i < 4; i++)
        chk($sformatf("lane%0d", i), cache_data_in[i],
            q[0].lanes[8*i +: 8]);
    end
  endtask

  task automatic cyc(bit v, logic [31:0] a, logic [31:0] d,
                     bit w, bit cr, logic [31:0] ld,
                     bit h, bit r);
    bit rdy;
    bit emp;
    st_valid = v;
    st_addr = a;
    st_data = d;
    is_word = w;
    cache_ready = cr;
    ld_check_addr = ld;
    halted_controller = h;
    reset = r;
    #1;
    check_outs();
    rdy = m_ready();
    emp = (q.size() == 0);
    @(posedge clk);
    if (r) begin
      q.delete();
      m_halt = 0;
      m_done = 0;
    end else begin
      if (!emp && cr) void'(q.pop_front());
      if (v && rdy) q.push_back(pack(a, d, w));
      if (m_halt && !m_done && emp) m_done = 1;
      if (!m_halt && h) m_halt = 1;
    end
    @(negedge clk);
  endtask

  task automatic idle(bit cr, logic [31:0] ld);
    cyc(0, 0, 0, 0, cr, ld, 0, 0);
  endtask

  initial begin
    total = 0;
    passed = 0;
    m_halt = 0;
    m_done = 0;
    st_valid = 0; st_addr = 0; st_data = 0; is_word = 0;
    cache_ready = 0; ld_check_addr = 0;
    halted_controller = 0; reset = 1;
    @(negedge clk);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);

    // reset state
    idle(0, 0);

    // word store
    cyc(1, 32'h100, 32'hAABBCCDD, 1, 1, 0, 0, 0);
    idle(1, 32'h100);
    idle(1, 32'h100);

    // byte stores
    cyc(1, 32'h201, 32'h123456F0, 0, 1, 0, 0, 0);
    cyc(1, 32'h203, 32'h123456F0, 0, 1, 0, 0, 0);
    idle(1, 0);
    idle(1, 0);

    // backpressure, held fifth request
    for (int i = 0; i < 4; i++)
      cyc(1, 32'h500 + 32'(i * 5), 32'h11111111 * (i + 1),
          i[0], 0, 0, 0, 0);
    for (int i = 0; i < 2; i++)
      cyc(1, 32'h600, 32'hCAFEF00D, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h600, 32'hCAFEF00D, 1, 1, 0, 0, 0);
    for (int i = 0; i < 6; i++) idle(1, 0);

    // load hazard
    cyc(1, 32'h302, 32'h000000A5, 0, 0, 32'h300, 0, 0);
    idle(0, 32'h300);
    idle(0, 32'h304);
    idle(1, 32'h300);
    idle(1, 32'h300);

    // random traffic with occasional halt and reset
    for (int n = 0; n < 600; n++) begin
      cyc($urandom_range(0, 3) != 0,
          32'h400 + 32'($urandom_range(0, 31)),
          $urandom, 1'($urandom),
          $urandom_range(0, 2) != 0,
          32'h400 + 32'($urandom_range(0, 31)),
          $urandom_range(0, 79) == 0,
          $urandom_range(0, 39) == 0);
    end

    // reset with three entries pending
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++)
      cyc(1, 32'h700 + 32'(i * 4), $urandom, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) idle(1, 32'h700);

    // halt with two pending
    cyc(1, 32'h800, 32'h01020304, 1, 0, 0, 0, 0);
    cyc(1, 32'h805, 32'h000000EE, 0, 0, 0, 0, 0);
    cyc(1, 32'h900, 32'h55555555, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++)
      cyc(1, 32'h904, 32'h66666666, 1, 0, 32'h800, 0, 0);
    for (int i = 0; i < 6; i++) idle(1, 32'h800);

    // halt while empty, then leave DONE by reset
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) idle(1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    idle(1, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
